// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_pkg
//  Purpose  : Shared pipeline definitions: data width, write-back select
//             encodings and MEM/WB control-bit positions.
//  Revision : 1.0  initial release
// ============================================================================
package pipeline_pkg;

   localparam int XLEN = 32;

   // Write-back source select encodings
   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_MEM  = 2'b01;
   localparam logic [1:0] WB_IMM  = 2'b10;
   localparam logic [1:0] WB_LINK = 2'b11;

   // Bit positions inside the 3-bit MEM/WB control bundle
   localparam int CTR_REGWRITE = 0;
   localparam int CTR_WBSEL_LO = 1;
   localparam int CTR_WBSEL_HI = 2;

   // Return address offset added to the PC for link write-backs
   localparam int LINK_OFFSET = 4;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/wb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : wb_mux
//  Purpose  : Write-back source selection (ALU / load / immediate / PC+4).
//  Revision : 1.0  initial release
// ============================================================================
module wb_mux #(
   parameter int XLEN = 32
) (
   input  logic [1:0]      wbSel_i,
   input  logic [XLEN-1:0] result_i,
   input  logic [XLEN-1:0] data_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [XLEN-1:0] addr_i,
   output logic [XLEN-1:0] wbData_o
);
   import pipeline_pkg::*;

   logic [XLEN-1:0] link_d;

   // Link address wraps naturally modulo 2^XLEN
   assign link_d = addr_i + XLEN'(LINK_OFFSET);

   // Select the write-back value from the four MEM/WB sources
   always_comb begin
      wbData_o = result_i;
      case (wbSel_i)
         WB_ALU:  wbData_o = result_i;
         WB_MEM:  wbData_o = data_i;
         WB_IMM:  wbData_o = imm_i;
         WB_LINK: wbData_o = link_d;
         default: wbData_o = result_i;
      endcase
   end

endmodule : wb_mux
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile
//  Purpose  : Write-back stage plus architectural register file with two
//             combinational read ports and same-cycle write-back bypass.
//             x0 is hardwired to zero; committed writes are counted.
//  Revision : 1.0  initial release
// ============================================================================
module wb_regfile #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clkIn,
   input  logic            resetIn,
   input  logic [2:0]      ctrSignalsIn,
   input  logic [XLEN-1:0] ResultIn,
   input  logic [XLEN-1:0] Imm32In,
   input  logic [XLEN-1:0] DataIn,
   input  logic [XLEN-1:0] AddrIn,
   input  logic [4:0]      rdIn,
   input  logic [4:0]      rs1In,
   input  logic [4:0]      rs2In,
   output logic [XLEN-1:0] rs1DataOut,
   output logic [XLEN-1:0] rs2DataOut,
   output logic [XLEN-1:0] wbDataOut,
   output logic            wbEnOut,
   output logic [31:0]     wbCountOut
);
   import pipeline_pkg::*;

   logic [XLEN-1:0] regs_q [NREG];
   logic [31:0]     wbCount_q;
   logic [31:0]     wbCount_d;
   logic [XLEN-1:0] wbData_d;
   logic            wbEn_d;
   logic [1:0]      wbSel_d;

   assign wbSel_d = ctrSignalsIn[CTR_WBSEL_HI:CTR_WBSEL_LO];

   wb_mux #(
      .XLEN     (XLEN)
   ) u_wb_mux (
      .wbSel_i  (wbSel_d),
      .result_i (ResultIn),
      .data_i   (DataIn),
      .imm_i    (Imm32In),
      .addr_i   (AddrIn),
      .wbData_o (wbData_d)
   );

   // Writes to x0 are dropped, so they neither commit nor count
   assign wbEn_d    = ctrSignalsIn[CTR_REGWRITE] && (rdIn != 5'd0);
   assign wbCount_d = wbCount_q + 32'd1;

   assign wbDataOut  = wbData_d;
   assign wbEnOut    = wbEn_d;
   assign wbCountOut = wbCount_q;

   // Register array: asynchronous clear, one committed write per cycle
   always_ff @(posedge clkIn or negedge resetIn) begin
      if (!resetIn) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wbEn_d) begin
         regs_q[rdIn] <= wbData_d;
      end
   end

   // Committed-write counter, wraps at 2^32
   always_ff @(posedge clkIn or negedge resetIn) begin
      if (!resetIn) begin
         wbCount_q <= '0;
      end else if (wbEn_d) begin
         wbCount_q <= wbCount_d;
      end
   end

   // Read port 1: x0 forced to zero, bypass a same-cycle commit
   always_comb begin
      rs1DataOut = regs_q[rs1In];
      if (rs1In == 5'd0) begin
         rs1DataOut = '0;
      end else if (wbEn_d && (rs1In == rdIn)) begin
         rs1DataOut = wbData_d;
      end
   end

   // Read port 2: x0 forced to zero, bypass a same-cycle commit
   always_comb begin
      rs2DataOut = regs_q[rs2In];
      if (rs2In == 5'd0) begin
         rs2DataOut = '0;
      end else if (wbEn_d && (rs2In == rdIn)) begin
         rs2DataOut = wbData_d;
      end
   end

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_regfile
//  Purpose  : Directed self-checking bench for wb_regfile.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_regfile;

   logic        clkIn;
   logic        resetIn;
   logic [2:0]  ctrSignalsIn;
   logic [31:0] ResultIn;
   logic [31:0] Imm32In;
   logic [31:0] DataIn;
   logic [31:0] AddrIn;
   logic [4:0]  rdIn;
   logic [4:0]  rs1In;
   logic [4:0]  rs2In;
   logic [31:0] rs1DataOut;
   logic [31:0] rs2DataOut;
   logic [31:0] wbDataOut;
   logic        wbEnOut;
   logic [31:0] wbCountOut;

   int n_checks = 0;
   int n_pass   = 0;

   wb_regfile #(
      .XLEN         (32),
      .NREG         (32)
   ) dut (
      .clkIn        (clkIn),
      .resetIn      (resetIn),
      .ctrSignalsIn (ctrSignalsIn),
      .ResultIn     (ResultIn),
      .Imm32In      (Imm32In),
      .DataIn       (DataIn),
      .AddrIn       (AddrIn),
      .rdIn         (rdIn),
      .rs1In        (rs1In),
      .rs2In        (rs2In),
      .rs1DataOut   (rs1DataOut),
      .rs2DataOut   (rs2DataOut),
      .wbDataOut    (wbDataOut),
      .wbEnOut      (wbEnOut),
      .wbCountOut   (wbCountOut)
   );

   initial clkIn = 1'b0;
   always #5 clkIn = ~clkIn;

   // Drive one MEM/WB bundle; ctr = {WBSel, RegWrite}
   task automatic drive(input logic [2:0] ctr, input logic [31:0] res,
                        input logic [31:0] data, input logic [31:0] imm,
                        input logic [31:0] addr, input logic [4:0] rd);
      ctrSignalsIn = ctr;
      ResultIn     = res;
      DataIn       = data;
      Imm32In      = imm;
      AddrIn       = addr;
      rdIn         = rd;
   endtask

   task automatic idle();
      drive(3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
   endtask

   // Advance past the next rising edge, then settle
   task automatic step();
      @(posedge clkIn);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rs1In = 5'd5; rs2In = 5'd31;
      #1;
      n_checks++;
      if (rs1DataOut !== 32'h0) $display("FAIL reset_rs1: got %h want %h", rs1DataOut, 32'h0);
      else n_pass++;
      n_checks++;
      if (rs2DataOut !== 32'h0) $display("FAIL reset_rs2: got %h want %h", rs2DataOut, 32'h0);
      else n_pass++;
      n_checks++;
      if (wbCountOut !== 32'h0) $display("FAIL reset_count: got %h want %h", wbCountOut, 32'h0);
      else n_pass++;
      n_checks++;
      if (wbEnOut !== 1'b0) $display("FAIL reset_wben: got %b want %b", wbEnOut, 1'b0);
      else n_pass++;
   endtask

   task automatic test_wbsel();
      logic [2:0]  ctr [4];
      logic [31:0] exp [4];
      ctr[0] = 3'b001; exp[0] = 32'h11;
      ctr[1] = 3'b011; exp[1] = 32'h22;
      ctr[2] = 3'b101; exp[2] = 32'h33;
      ctr[3] = 3'b111; exp[3] = 32'h104;
      for (int i = 0; i < 4; i++) begin
         drive(ctr[i], 32'h11, 32'h22, 32'h33, 32'h100, 5'd5);
         rs1In = 5'd0;
         #1;
         n_checks++;
         if (wbDataOut !== exp[i]) $display("FAIL wbsel%0d_data: got %h want %h", i, wbDataOut, exp[i]);
         else n_pass++;
         step();
         idle();
         rs1In = 5'd5;
         #1;
         n_checks++;
         if (rs1DataOut !== exp[i]) $display("FAIL wbsel%0d_reg5: got %h want %h", i, rs1DataOut, exp[i]);
         else n_pass++;
      end
      n_checks++;
      if (wbCountOut !== 32'd4) $display("FAIL wbsel_count: got %0d want %0d", wbCountOut, 4);
      else n_pass++;
   endtask

   task automatic test_rd0();
      drive(3'b001, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 5'd0);
      rs1In = 5'd0;
      #1;
      n_checks++;
      if (rs1DataOut !== 32'h0) $display("FAIL rd0_read: got %h want %h", rs1DataOut, 32'h0);
      else n_pass++;
      n_checks++;
      if (wbEnOut !== 1'b0) $display("FAIL rd0_wben: got %b want %b", wbEnOut, 1'b0);
      else n_pass++;
      step();
      idle();
      #1;
      n_checks++;
      if (wbCountOut !== 32'd4) $display("FAIL rd0_count: got %0d want %0d", wbCountOut, 4);
      else n_pass++;
   endtask

   task automatic test_bypass();
      drive(3'b001, 32'hA, 32'h0, 32'h0, 32'h0, 5'd7);
      step();
      drive(3'b001, 32'hB, 32'h0, 32'h0, 32'h0, 5'd7);
      rs1In = 5'd7; rs2In = 5'd7;
      #1;
      n_checks++;
      if (rs1DataOut !== 32'hB) $display("FAIL bypass_rs1: got %h want %h", rs1DataOut, 32'hB);
      else n_pass++;
      n_checks++;
      if (rs2DataOut !== 32'hB) $display("FAIL bypass_rs2: got %h want %h", rs2DataOut, 32'hB);
      else n_pass++;
      step();
      idle();
      #1;
      n_checks++;
      if (rs1DataOut !== 32'hB) $display("FAIL bypass_array: got %h want %h", rs1DataOut, 32'hB);
      else n_pass++;
      n_checks++;
      if (wbCountOut !== 32'd6) $display("FAIL bypass_count: got %0d want %0d", wbCountOut, 6);
      else n_pass++;
   endtask

   task automatic test_nowrite();
      drive(3'b000, 32'h55, 32'h0, 32'h0, 32'h0, 5'd3);
      rs1In = 5'd3;
      #1;
      n_checks++;
      if (wbDataOut !== 32'h55) $display("FAIL nowrite_data: got %h want %h", wbDataOut, 32'h55);
      else n_pass++;
      n_checks++;
      if (rs1DataOut !== 32'h0) $display("FAIL nowrite_nobypass: got %h want %h", rs1DataOut, 32'h0);
      else n_pass++;
      step();
      idle();
      #1;
      n_checks++;
      if (rs1DataOut !== 32'h0) $display("FAIL nowrite_reg3: got %h want %h", rs1DataOut, 32'h0);
      else n_pass++;
      n_checks++;
      if (wbCountOut !== 32'd6) $display("FAIL nowrite_count: got %0d want %0d", wbCountOut, 6);
      else n_pass++;
   endtask

   task automatic test_link_wrap();
      drive(3'b001, 32'h77, 32'h0, 32'h0, 32'h0, 5'd1);
      step();
      drive(3'b111, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd1);
      #1;
      n_checks++;
      if (wbDataOut !== 32'h0) $display("FAIL link_data: got %h want %h", wbDataOut, 32'h0);
      else n_pass++;
      step();
      idle();
      rs1In = 5'd1;
      #1;
      n_checks++;
      if (rs1DataOut !== 32'h0) $display("FAIL link_reg1: got %h want %h", rs1DataOut, 32'h0);
      else n_pass++;
      n_checks++;
      if (wbCountOut !== 32'd8) $display("FAIL link_count: got %0d want %0d", wbCountOut, 8);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      rs1In = 5'd5; rs2In = 5'd7;
      #1;
      n_checks++;
      if (rs2DataOut !== 32'hB) $display("FAIL prereset_reg7: got %h want %h", rs2DataOut, 32'hB);
      else n_pass++;
      // Mid-cycle assertion, no clock edge in between
      #2;
      resetIn = 1'b0;
      #1;
      n_checks++;
      if (rs1DataOut !== 32'h0) $display("FAIL areset_rs1: got %h want %h", rs1DataOut, 32'h0);
      else n_pass++;
      n_checks++;
      if (rs2DataOut !== 32'h0) $display("FAIL areset_rs2: got %h want %h", rs2DataOut, 32'h0);
      else n_pass++;
      n_checks++;
      if (wbCountOut !== 32'h0) $display("FAIL areset_count: got %0d want %0d", wbCountOut, 0);
      else n_pass++;
      // A write presented across an edge while reset is held is discarded
      drive(3'b001, 32'h99, 32'h0, 32'h0, 32'h0, 5'd9);
      step();
      #2;
      resetIn = 1'b1;
      idle();
      rs1In = 5'd9;
      #1;
      n_checks++;
      if (rs1DataOut !== 32'h0) $display("FAIL inreset_write: got %h want %h", rs1DataOut, 32'h0);
      else n_pass++;
      n_checks++;
      if (wbCountOut !== 32'h0) $display("FAIL inreset_count: got %0d want %0d", wbCountOut, 0);
      else n_pass++;
      // First commit after release
      drive(3'b001, 32'h42, 32'h0, 32'h0, 32'h0, 5'd9);
      step();
      idle();
      #1;
      n_checks++;
      if (rs1DataOut !== 32'h42) $display("FAIL postreset_reg9: got %h want %h", rs1DataOut, 32'h42);
      else n_pass++;
      n_checks++;
      if (wbCountOut !== 32'd1) $display("FAIL postreset_count: got %0d want %0d", wbCountOut, 1);
      else n_pass++;
   endtask

   initial begin
      resetIn = 1'b0;
      idle();
      rs1In = 5'd0;
      rs2In = 5'd0;
      #12;
      test_reset();
      #1;
      resetIn = 1'b1;
      step();
      test_wbsel();
      test_rd0();
      test_bypass();
      test_nowrite();
      test_link_wrap();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_wb_regfile
`default_nettype wire
